// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan controller.
// All segment patterns are active-low, segment a in the MSB.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    BlinkOn,
    BlinkOff
  } blink_phase_e;

  // Segments a..g, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'b1111111;
    unique case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side load interface and display-side outputs of the seven-segment scan controller.
interface seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 8
);

  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS-1:0]     blink;
  logic                  lz_sup;
  logic                  pending;
  logic                  frame_tick;
  logic [DIGITS-1:0]     AN;
  logic [7:0]            dig;

  modport master (
    output load, data, dp, blank, blink, lz_sup,
    input  pending, frame_tick, AN, dig
  );

  modport slave (
    input  load, data, dp, blank, blink, lz_sup,
    output pending, frame_tick, AN, dig
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder with decimal point and a dark override.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       dark_i,
  output logic [7:0] dig_o
);

  always_comb begin
    dig_o = SEG_BLANK;
    if (!dark_i) begin
      dig_o = {hex_to_seg(nib_i), ~dp_i};
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: frame-aligned data commit, guard interval,
// blanking, blink and leading-zero suppression over DIGITS common-anode digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned DIV          = 100000,
  parameter int unsigned GUARD        = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic            clk,
  input logic            Reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SelW = $clog2(DIGITS);
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [SelW-1:0] SelLast = SelW'(DIGITS - 1);
  localparam logic [FrmW-1:0] FrmLast = FrmW'(BLINK_FRAMES - 1);
  localparam logic [CntW-1:0] GuardC  = CntW'(GUARD);

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink;
  } disp_set_t;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [FrmW-1:0] frm_q, frm_d;
  blink_phase_e    phase_q, phase_d;
  logic            tick_q, tick_d;
  disp_set_t       act_q, act_d;
  disp_set_t       pnd_q, pnd_d;
  logic            pending_q, pending_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]      dig_q, dig_d;

  disp_set_t         in_set;
  logic [DIGITS-1:0] lz_dark;
  logic [3:0]        sel_nib;
  logic              sel_dark;
  logic              guard;
  logic [7:0]        dec_dig;

  assign in_set.data  = bus.data;
  assign in_set.dp    = bus.dp;
  assign in_set.blank = bus.blank;
  assign in_set.blink = bus.blink;

  // Dwell and digit-select counters; frame_tick is precomputed from the next state so the
  // registered flag lines up with the last cycle of the frame.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      sel_d = (sel_q == SelLast) ? '0 : sel_q + 1'b1;
    end
    tick_d = (cnt_d == CntLast) && (sel_d == SelLast);
  end

  // A set loaded on the frame's last cycle goes straight to the active set.
  always_comb begin
    act_d     = act_q;
    pnd_d     = pnd_q;
    pending_d = pending_q;
    frm_d     = frm_q;
    phase_d   = phase_q;
    if (tick_q) begin
      if (bus.load) begin
        act_d = in_set;
      end else if (pending_q) begin
        act_d = pnd_q;
      end
      pending_d = 1'b0;
      if (frm_q == FrmLast) begin
        frm_d   = '0;
        phase_d = (phase_q == BlinkOn) ? BlinkOff : BlinkOn;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end else if (bus.load) begin
      pnd_d     = in_set;
      pending_d = 1'b1;
    end
  end

  // Digit i (i > 0) is suppressed when it and every higher nibble are zero.
  always_comb begin : lz_mask
    logic zero_above;
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (act_q.data[4*i +: 4] == 4'h0);
      lz_dark[i] = bus.lz_sup && zero_above;
    end
  end

  always_comb begin
    sel_nib  = act_q.data[{sel_q, 2'b00} +: 4];
    sel_dark = act_q.blank[sel_q] ||
               (act_q.blink[sel_q] && (phase_q == BlinkOff)) ||
               lz_dark[sel_q];
  end

  seg_hex_decode u_dec (
    .nib_i  (sel_nib),
    .dp_i   (act_q.dp[sel_q]),
    .dark_i (sel_dark),
    .dig_o  (dec_dig)
  );

  always_comb begin
    guard = (cnt_q < GuardC);
    an_d  = '1;
    dig_d = SEG_BLANK;
    if (!guard) begin
      an_d  = ~(DIGITS'(1) << sel_q);
      dig_d = dec_dig;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt_q     <= '0;
      sel_q     <= '0;
      frm_q     <= '0;
      phase_q   <= BlinkOn;
      tick_q    <= 1'b0;
      act_q     <= '0;
      pnd_q     <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      dig_q     <= SEG_BLANK;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      frm_q     <= frm_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      act_q     <= act_d;
      pnd_q     <= pnd_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      dig_q     <= dig_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_tick = tick_q;
  assign bus.AN         = an_q;
  assign bus.dig        = dig_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIGITS=4, DIV=8, GUARD=2, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned DIV          = 8;
  localparam int unsigned GUARD        = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int          FRAME        = DIGITS * DIV;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk = 1'b0;
  logic Reset;
  int   nvec = 0;
  int   nerr = 0;
  int   k = 0;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .DIV          (DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // One clock; outputs are then sampled on the falling edge. k counts rising edges since reset.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic goto(input int t);
    while (k % FRAME != t) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                         input logic [3:0] bk);
    bus.data  = d;
    bus.dp    = p;
    bus.blank = bl;
    bus.blink = bk;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    Reset      = 1'b1;
    bus.load   = 1'b0;
    bus.data   = '0;
    bus.dp     = '0;
    bus.blank  = '0;
    bus.blink  = '0;
    bus.lz_sup = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nvec += 4;
    if (bus.AN !== 4'hF) begin nerr++; $display("FAIL reset_AN: got %b want 1111", bus.AN); end
    if (bus.dig !== 8'hFF) begin nerr++; $display("FAIL reset_dig: got %h want ff", bus.dig); end
    if (bus.pending !== 1'b0) begin
      nerr++; $display("FAIL reset_pending: got %b want 0", bus.pending);
    end
    if (bus.frame_tick !== 1'b0) begin
      nerr++; $display("FAIL reset_tick: got %b want 0", bus.frame_tick);
    end
    Reset = 1'b0;
    k = 0;
  endtask

  task automatic test_scan();
    int c, s;
    logic [3:0] e_an;
    logic [7:0] e_dig;
    logic e_tick;
    for (int n = 1; n <= FRAME + 1; n++) begin
      tick();
      c = (k - 1) % DIV;
      s = ((k - 1) / DIV) % DIGITS;
      e_an = 4'b0001 << s;
      e_an = (c < GUARD) ? 4'hF : ~e_an;
      e_dig = (c < GUARD) ? 8'hFF : 8'b00000011;
      e_tick = (k % FRAME == FRAME - 1);
      nvec += 3;
      if (bus.AN !== e_an) begin
        nerr++; $display("FAIL scan_AN k=%0d: got %b want %b", k, bus.AN, e_an);
      end
      if (bus.dig !== e_dig) begin
        nerr++; $display("FAIL scan_dig k=%0d: got %b want %b", k, bus.dig, e_dig);
      end
      if (bus.frame_tick !== e_tick) begin
        nerr++; $display("FAIL scan_tick k=%0d: got %b want %b", k, bus.frame_tick, e_tick);
      end
    end
  endtask

  task automatic test_load();
    logic [7:0] exp_d [4];
    logic [3:0] e_an;
    exp_d = '{8'b01110001, 8'b00010001, 8'b00100101, 8'b10011111};
    goto(10);
    do_load(16'h12AF, 4'h0, 4'h0, 4'h0);
    nvec++;
    if (bus.pending !== 1'b1) begin
      nerr++; $display("FAIL load_pending_set: got %b want 1", bus.pending);
    end
    goto(21);
    nvec++;
    if (bus.dig !== 8'b00000011) begin
      nerr++; $display("FAIL load_not_early: got %b want 00000011", bus.dig);
    end
    goto(FRAME - 1);
    nvec += 2;
    if (bus.pending !== 1'b1) begin
      nerr++; $display("FAIL load_pending_hold: got %b want 1", bus.pending);
    end
    if (bus.frame_tick !== 1'b1) begin
      nerr++; $display("FAIL load_tick: got %b want 1", bus.frame_tick);
    end
    tick();
    nvec++;
    if (bus.pending !== 1'b0) begin
      nerr++; $display("FAIL load_pending_clr: got %b want 0", bus.pending);
    end
    for (int s = 0; s < 4; s++) begin
      goto(8 * s + 5);
      e_an = ~(4'b0001 << s);
      nvec += 2;
      if (bus.AN !== e_an) begin
        nerr++; $display("FAIL load_AN d%0d: got %b want %b", s, bus.AN, e_an);
      end
      if (bus.dig !== exp_d[s]) begin
        nerr++; $display("FAIL load_dig d%0d: got %b want %b", s, bus.dig, exp_d[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    goto(3);
    do_load(16'h1111, 4'h0, 4'h0, 4'h0);
    goto(12);
    do_load(16'h2222, 4'h0, 4'h0, 4'h0);
    goto(FRAME - 1);
    tick();
    for (int s = 0; s < 4; s++) begin
      goto(8 * s + 5);
      nvec++;
      if (bus.dig !== 8'b00100101) begin
        nerr++; $display("FAIL b2b_last_wins d%0d: got %b want 00100101", s, bus.dig);
      end
    end
    goto(FRAME - 1);
    do_load(16'h3333, 4'h0, 4'h0, 4'h0);
    nvec++;
    if (bus.pending !== 1'b0) begin
      nerr++; $display("FAIL b2b_direct_pending: got %b want 0", bus.pending);
    end
    for (int s = 0; s < 4; s++) begin
      goto(8 * s + 5);
      nvec++;
      if (bus.dig !== 8'b00001101) begin
        nerr++; $display("FAIL b2b_direct d%0d: got %b want 00001101", s, bus.dig);
      end
    end
  endtask

  task automatic test_hex();
    logic [15:0] words [4];
    logic [3:0]  nib;
    logic [7:0]  e_dig;
    words = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    for (int w = 0; w < 4; w++) begin
      goto(3);
      do_load(words[w], 4'h0, 4'h0, 4'h0);
      goto(FRAME - 1);
      tick();
      for (int s = 0; s < 4; s++) begin
        goto(8 * s + 5);
        nib = 4'((words[w] >> (4 * s)) & 16'hF);
        e_dig = {SEG[nib], 1'b1};
        nvec++;
        if (bus.dig !== e_dig) begin
          nerr++; $display("FAIL hex_%h: got %b want %b", nib, bus.dig, e_dig);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'b00000011, 8'b10011001, 8'hFF, 8'hFF};
    exp_b = '{8'b00000011, 8'hFF, 8'hFF, 8'hFF};
    bus.lz_sup = 1'b1;
    goto(3);
    do_load(16'h0040, 4'h0, 4'h0, 4'h0);
    goto(FRAME - 1);
    tick();
    for (int s = 0; s < 4; s++) begin
      goto(8 * s + 5);
      nvec++;
      if (bus.dig !== exp_a[s]) begin
        nerr++; $display("FAIL lz_0040 d%0d: got %b want %b", s, bus.dig, exp_a[s]);
      end
      if (s == 2) begin
        nvec++;
        if (bus.AN !== 4'b1011) begin
          nerr++; $display("FAIL lz_anode d2: got %b want 1011", bus.AN);
        end
      end
    end
    goto(3);
    do_load(16'h0000, 4'h0, 4'h0, 4'h0);
    goto(FRAME - 1);
    tick();
    for (int s = 0; s < 4; s++) begin
      goto(8 * s + 5);
      nvec++;
      if (bus.dig !== exp_b[s]) begin
        nerr++; $display("FAIL lz_0000 d%0d: got %b want %b", s, bus.dig, exp_b[s]);
      end
    end
    bus.lz_sup = 1'b0;
  endtask

  task automatic test_blink();
    int m;
    logic [7:0] e_dig;
    goto(3);
    do_load(16'h0000, 4'b0001, 4'b0100, 4'b0001);
    goto(FRAME - 1);
    tick();
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < 4; s++) begin
        goto(8 * s + 5);
        m = k / FRAME;
        if (s == 0) e_dig = (((m / BLINK_FRAMES) % 2) == 1) ? 8'hFF : 8'b00000010;
        else if (s == 2) e_dig = 8'hFF;
        else e_dig = 8'b00000011;
        nvec++;
        if (bus.dig !== e_dig) begin
          nerr++; $display("FAIL blink f%0d d%0d: got %b want %b", m, s, bus.dig, e_dig);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    goto(3);
    do_load(16'h5555, 4'hF, 4'h0, 4'h0);
    nvec++;
    if (bus.pending !== 1'b1) begin
      nerr++; $display("FAIL rmid_pending_pre: got %b want 1", bus.pending);
    end
    goto(13);
    Reset = 1'b1;
    tick();
    nvec += 4;
    if (bus.AN !== 4'hF) begin nerr++; $display("FAIL rmid_AN: got %b want 1111", bus.AN); end
    if (bus.dig !== 8'hFF) begin nerr++; $display("FAIL rmid_dig: got %h want ff", bus.dig); end
    if (bus.pending !== 1'b0) begin
      nerr++; $display("FAIL rmid_pending: got %b want 0", bus.pending);
    end
    if (bus.frame_tick !== 1'b0) begin
      nerr++; $display("FAIL rmid_tick: got %b want 0", bus.frame_tick);
    end
    Reset = 1'b0;
    k = 0;
    for (int n = 1; n <= FRAME + 5; n++) begin
      tick();
      if (k == 5 || k == FRAME + 5) begin
        nvec += 3;
        if (bus.AN !== 4'b1110) begin
          nerr++; $display("FAIL rmid_scan_AN k=%0d: got %b want 1110", k, bus.AN);
        end
        if (bus.dig !== 8'b00000011) begin
          nerr++; $display("FAIL rmid_lost k=%0d: got %b want 00000011", k, bus.dig);
        end
        if (bus.pending !== 1'b0) begin
          nerr++; $display("FAIL rmid_pending_post k=%0d: got %b want 0", k, bus.pending);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_hex();
    test_lz();
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller for the board-level display path: drives DIGITS common-anode digits from a packed hex word, with per-digit decimal points, blanking, blink and leading-zero suppression. New data is accepted on a load strobe and committed only at a frame boundary, so a frame never mixes old and new digits. A guard interval at each digit change prevents ghosting. It supersedes the fixed 4-digit scan/select logic in the display top levels.

## Interface
- DIGITS, 8, number of digits scanned (2..16)
- DIV, 100000, clk cycles per digit dwell (DIV > GUARD)
- GUARD, 16, cycles at start of each dwell with all anodes off (0 disables the guard)
- BLINK_FRAMES, 64, frames per blink half-period (>= 1)

- clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- load  in  1  one-cycle strobe; captures data/dp/blank/blink into pending set
- data  in  4*DIGITS  hex nibbles; nibble i = data[4i+3:4i] shows on digit i
- dp  in  DIGITS  decimal point on for digit i when dp[i]=1
- blank  in  DIGITS  digit i forced dark when blank[i]=1
- blink  in  DIGITS  digit i dark during blink-off phase when blink[i]=1
- lz_sup  in  1  leading-zero suppression enable (live, not latched)
- pending  out  1  loaded set awaiting commit
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame
- AN  out  DIGITS  anodes, active-low, one-hot-low; AN[i]=0 selects digit i
- dig  out  8  segments a..g on dig[7:1], dp on dig[0]; all active-low

## Operation
- Dwell counter cnt: 0..DIV-1. At cnt==DIV-1, cnt wraps to 0 and sel advances; sel wraps from DIGITS-1 to 0.
- frame_tick=1 exactly when cnt==DIV-1 and sel==DIGITS-1.
- Commit on a frame_tick cycle. The active set takes load-cycle inputs if load=1 in that cycle, else the pending set; pending clears.
- load with no frame_tick: pending set is overwritten, pending=1. Successive loads keep the last one.
- Blink: frame counter counts frame_ticks to BLINK_FRAMES-1, then wraps and toggles blink_phase. Digits with active blink[i]=1 go dark when blink_phase=1.
- Leading-zero suppression (lz_sup=1): digit i>0 is dark if its nibble and all higher nibbles are 0. Digit 0 is never suppressed. The dp of a suppressed digit is also dark.
- Dark digit: dig=8'hFF, anode still driven.
- Decode, bits 7..1: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
- Guard: while cnt<GUARD, AN is all ones and dig=8'hFF.

## Timing
- Reset values:
  - cnt=0, sel=0, frame count 0, blink_phase=0
  - active and pending sets all zero; pending=0, frame_tick=0
  - AN all ones, dig=8'hFF
- AN/dig are registered from the current cnt/sel/active set, so they lag one clk.
- frame_tick is registered aligned with its cycle definition (combinational compare registered one cycle early).
- Frame length is DIGITS*DIV cycles. A load is visible at most one frame plus one cycle later.
- Reset mid-frame aborts the scan immediately. A pending load is lost.

## Structure
- Package seg_pkg holds:
  - SEG_BLANK = 8'hFF
  - the 16-entry hex-to-segment constant/function
- Sub-module seg_hex_decode: 4-bit nibble + dp + dark in, 8-bit dig out (combinational). Instantiated once on the selected nibble.
- Counters, commit logic, lz/blink masks and output registers stay in seg_scan_ctrl.

## Test plan
Bench parameters: DIGITS=4, DIV=8, GUARD=2, BLINK_FRAMES=2.
- Reset release, no load: AN=4'b1111 during guard, then AN cycles 1110,1101,1011,0111 with dig=8'b00000011; frame_tick every 32 cycles.
- load data=16'h12AF mid-frame: pending=1 until the next frame_tick. Next frame shows digit0=8'b01110001 and digit3=8'b10011111.
- Two loads in one frame (16'h1111, then 16'h2222): only 2s are displayed. load coinciding with frame_tick commits directly, and pending stays 0.
- lz_sup=1 with data=16'h0040: digits 3 and 2 show FF, digit1=8'b10011001, digit0=8'b00000011. With data=16'h0000, only digit 0 is lit.
- blink=4'b0001 with dp=4'b0001: digit0 dig[0]=0 for 2 frames, then dig=FF for 2 frames, repeating.
- Assert Reset mid-dwell with pending=1: all outputs return to reset values the next cycle, and the old data is not committed.
